sumador_acc_param: RTL and testbench
====================================

Name: sumador_acc_param

Overview:
- Parametrised successor to the team's small fixed-width adder; generalises operand width, signedness and result width.
- Adds a subtract mode, a running accumulator with saturate or wrap, and a sticky overflow flag.
- Adds a valid/ready handshake with a one-cycle registered output.
- Sits between the pad-level wrapper (operands from ui_in/uio_in) and uo_out, or chains to downstream datapath blocks.

Parameters:
- WIDTH, 5, operand width in bits (a, b).
- ACC_W, 8, result/accumulator width; must be >= WIDTH+1.
- SIGNED, 1, 1 = two's-complement operands/result, 0 = unsigned.
- SATURATE, 1, 1 = clamp on overflow, 0 = wrap modulo 2^ACC_W.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operand/op present.
- in_ready  out  1  block can accept this cycle.
- op  in  2  00 ADD, 01 SUB, 10 ACC, 11 CLR.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B (ignored for ACC/CLR).
- out_valid  out  1  result register holds an undelivered result.
- out_ready  in  1  downstream accepts result.
- result  out  ACC_W  registered result.
- acc  out  ACC_W  current accumulator value (registered).
- ovf  out  1  sticky overflow/underflow flag.

Behaviour:
- Reset: one clock with rst_n=0 applies, whatever the other inputs. It sets out_valid=0, result=0, acc=0 and ovf=0, and drops any in-flight result. in_ready is 1 on the first cycle after reset.
- in_ready = !out_valid || out_ready. This is combinational, with no dependence on in_valid.
- Accept = in_valid && in_ready. On accept, the next edge loads result, sets out_valid=1 and updates acc/ovf per op. Latency is 1 cycle.
- Throughput is 1 per cycle when out_ready is held 1.
- Delivery = out_valid && out_ready.
  - Delivery without accept clears out_valid.
  - Delivery and accept in the same cycle keep out_valid=1 and load the new result.
- While out_valid && !out_ready: result, acc and ovf hold stable and in_ready=0.
- Operand extension: sign-extend when SIGNED=1, zero-extend when SIGNED=0, to ACC_W+1 bits for internal arithmetic.
- ADD: result = ext(a)+ext(b). This is exact for SIGNED=1 (ACC_W >= WIDTH+1). acc and ovf are unchanged.
- SUB: result = ext(a)-ext(b). acc is unchanged.
  - SIGNED=0 with a<b: result = 0 if SATURATE, else the low ACC_W bits; ovf<=1 in both cases.
- ACC: sum = acc+ext(a). If sum is out of range:
  - SATURATE=1: clamp to max (signed 2^(ACC_W-1)-1, unsigned 2^ACC_W-1) or to signed min -2^(ACC_W-1).
  - SATURATE=0: take the low ACC_W bits.
  - Either way, ovf<=1.
  - acc<=clamped/wrapped sum, and result equals the new acc.
- CLR: acc<=0, ovf<=0, result<=0. It is a normal handshaked transaction (out_valid asserts).
- ovf: set only by out-of-range ACC or unsigned SUB underflow; cleared only by CLR or reset. Set and clear never coincide (one op per accept).
- No state changes without accept, except out_valid clearing on delivery.
- Inputs are sampled only on accept. a/b/op may change freely otherwise.

Test Plan:
- Defaults, reset held 2 cycles with in_valid=1 -> out_valid=0, acc=0, ovf=0. The first edge after rst_n=1 with ADD a=3,b=4 gives result=7 and out_valid=1 one cycle later.
- Signed ADD a=-16,b=-16 -> result=-32 (0xE0), ovf=0. SUB a=15,b=-16 -> result=31.
- ACC a=15 nine times, SATURATE=1, out_ready=1 -> acc 15,30,...,120, then 127; ovf=1 from the 9th result. CLR -> acc=0, ovf=0, result=0.
- Same sequence with SATURATE=0 -> 9th result=-121 (0x87), ovf=1.
- SIGNED=0, SATURATE=1, SUB a=3,b=5 -> result=0, ovf=1. With SATURATE=0 -> result=254, ovf=1.
- Backpressure: out_ready=0 for 3 cycles after a result, with in_valid=1 ADD 1+1 -> in_ready=0 and result held. out_ready=1 -> same-cycle deliver+accept, result=2 next cycle, out_valid stays 1. Reset asserted while out_valid=1 -> out_valid=0 and acc=0 next cycle.

Source files
------------

// File: rtl/sumador_acc_param.sv
// Parametrised add/sub/accumulate unit with valid/ready handshake,
// one-cycle registered result, saturate-or-wrap accumulator, sticky ovf.
module sumador_acc_param #(
   parameter int WIDTH    = 5,
   parameter int ACC_W    = 8,
   parameter int SIGNED   = 1,
   parameter int SATURATE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] result,
   output logic [ACC_W-1:0] acc,
   output logic             ovf
);

   localparam int EW = ACC_W + 1;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_ACC = 2'b10;
   localparam logic [1:0] OP_CLR = 2'b11;

   localparam logic [ACC_W-1:0] MAXV = (SIGNED != 0) ?
      {1'b0, {(ACC_W-1){1'b1}}} : {ACC_W{1'b1}};
   localparam logic [ACC_W-1:0] MINV = (SIGNED != 0) ?
      {1'b1, {(ACC_W-1){1'b0}}} : {ACC_W{1'b0}};

   logic             out_valid_q, out_valid_d;
   logic [ACC_W-1:0] result_q, result_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic             ovf_q, ovf_d;

   logic             sa, sb, sc;
   logic [EW-1:0]    ea, eb, eacc;
   logic [ACC_W-1:0] add_r;
   logic [EW-1:0]    dif_w, acs_w;
   logic             acc_oor, sub_unf, accept;

   assign sa   = (SIGNED != 0) ? a[WIDTH-1] : 1'b0;
   assign sb   = (SIGNED != 0) ? b[WIDTH-1] : 1'b0;
   assign sc   = (SIGNED != 0) ? acc_q[ACC_W-1] : 1'b0;
   assign ea   = {{(EW-WIDTH){sa}}, a};
   assign eb   = {{(EW-WIDTH){sb}}, b};
   assign eacc = {sc, acc_q};

   assign add_r = ea[ACC_W-1:0] + eb[ACC_W-1:0];
   assign dif_w = ea - eb;
   assign acs_w = eacc + ea;

   // Signed sums leave range when the guard bit disagrees with the sign bit.
   assign acc_oor = (SIGNED != 0) ?
      (acs_w[EW-1] != acs_w[EW-2]) : acs_w[EW-1];
   assign sub_unf = (SIGNED == 0) && dif_w[EW-1];

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   always_comb begin
      out_valid_d = out_valid_q;
      result_d    = result_q;
      acc_d       = acc_q;
      ovf_d       = ovf_q;
      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
      if (accept) begin
         out_valid_d = 1'b1;
         case (op)
            OP_ADD: result_d = add_r;
            OP_SUB: begin
               if (sub_unf) begin
                  result_d = (SATURATE != 0) ? MINV : dif_w[ACC_W-1:0];
                  ovf_d    = 1'b1;
               end else begin
                  result_d = dif_w[ACC_W-1:0];
               end
            end
            OP_ACC: begin
               if (acc_oor) begin
                  ovf_d = 1'b1;
                  if (SATURATE != 0) begin
                     acc_d = ((SIGNED != 0) && acs_w[EW-1]) ? MINV : MAXV;
                  end else begin
                     acc_d = acs_w[ACC_W-1:0];
                  end
               end else begin
                  acc_d = acs_w[ACC_W-1:0];
               end
               result_d = acc_d;
            end
            OP_CLR: begin
               acc_d    = '0;
               ovf_d    = 1'b0;
               result_d = '0;
            end
            default: result_d = result_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         result_q    <= '0;
         acc_q       <= '0;
         ovf_q       <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         acc_q       <= acc_d;
         ovf_q       <= ovf_d;
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign acc       = acc_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_sumador_acc_param.sv
// Directed bench: four instances covering SIGNED x SATURATE share stimulus,
// each output checked against hand-computed values.
module tb_sumador_acc_param;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       out_ready;
   logic [1:0] op;
   logic [4:0] a, b;

   logic       ir  [4];
   logic       ov  [4];
   logic [7:0] res [4];
   logic [7:0] ac  [4];
   logic       of  [4];

   int nvec = 0;
   int nerr = 0;

   sumador_acc_param #(.WIDTH(5), .ACC_W(8), .SIGNED(1), .SATURATE(1)) u0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
      .op(op), .a(a), .b(b), .out_valid(ov[0]), .out_ready(out_ready),
      .result(res[0]), .acc(ac[0]), .ovf(of[0]));
   sumador_acc_param #(.WIDTH(5), .ACC_W(8), .SIGNED(1), .SATURATE(0)) u1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
      .op(op), .a(a), .b(b), .out_valid(ov[1]), .out_ready(out_ready),
      .result(res[1]), .acc(ac[1]), .ovf(of[1]));
   sumador_acc_param #(.WIDTH(5), .ACC_W(8), .SIGNED(0), .SATURATE(1)) u2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
      .op(op), .a(a), .b(b), .out_valid(ov[2]), .out_ready(out_ready),
      .result(res[2]), .acc(ac[2]), .ovf(of[2]));
   sumador_acc_param #(.WIDTH(5), .ACC_W(8), .SIGNED(0), .SATURATE(0)) u3 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[3]),
      .op(op), .a(a), .b(b), .out_valid(ov[3]), .out_ready(out_ready),
      .result(res[3]), .acc(ac[3]), .ovf(of[3]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] o,
                      input logic [31:0] e);
      nvec++;
      assert (o === e) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, o, e);
      end
   endtask

   task automatic c_res(input string tag, input logic [7:0] e0,
                        input logic [7:0] e1, input logic [7:0] e2,
                        input logic [7:0] e3);
      logic [7:0] e [4];
      e = '{e0, e1, e2, e3};
      for (int i = 0; i < 4; i++)
         chk($sformatf("%s.res%0d", tag, i), {24'd0, res[i]}, {24'd0, e[i]});
   endtask

   task automatic c_acc(input string tag, input logic [7:0] e0,
                        input logic [7:0] e1, input logic [7:0] e2,
                        input logic [7:0] e3);
      logic [7:0] e [4];
      e = '{e0, e1, e2, e3};
      for (int i = 0; i < 4; i++)
         chk($sformatf("%s.acc%0d", tag, i), {24'd0, ac[i]}, {24'd0, e[i]});
   endtask

   task automatic c_ovf(input string tag, input logic e0, input logic e1,
                        input logic e2, input logic e3);
      logic e [4];
      e = '{e0, e1, e2, e3};
      for (int i = 0; i < 4; i++)
         chk($sformatf("%s.ovf%0d", tag, i), {31'd0, of[i]}, {31'd0, e[i]});
   endtask

   task automatic c_hs(input string tag, input logic e_ov, input logic e_ir);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("%s.ov%0d", tag, i), {31'd0, ov[i]}, {31'd0, e_ov});
         chk($sformatf("%s.ir%0d", tag, i), {31'd0, ir[i]}, {31'd0, e_ir});
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] o,
                        input logic [4:0] aa, input logic [4:0] bb);
      in_valid = v;
      op       = o;
      a        = aa;
      b        = bb;
   endtask

   initial begin
      rst_n     = 1'b0;
      out_ready = 1'b1;
      drive(1'b1, 2'b00, 5'd3, 5'd4);
      cyc();
      cyc();
      c_hs("rst", 1'b0, 1'b1);
      c_res("rst", 8'h00, 8'h00, 8'h00, 8'h00);
      c_acc("rst", 8'h00, 8'h00, 8'h00, 8'h00);
      c_ovf("rst", 1'b0, 1'b0, 1'b0, 1'b0);

      rst_n = 1'b1;
      cyc();
      c_hs("add37", 1'b1, 1'b1);
      c_res("add37", 8'h07, 8'h07, 8'h07, 8'h07);

      drive(1'b0, 2'b00, 5'd0, 5'd0);
      cyc();
      c_hs("drain", 1'b0, 1'b1);

      drive(1'b1, 2'b00, 5'h10, 5'h10);
      cyc();
      c_res("addneg", 8'hE0, 8'hE0, 8'h20, 8'h20);
      c_ovf("addneg", 1'b0, 1'b0, 1'b0, 1'b0);

      drive(1'b1, 2'b01, 5'd15, 5'h10);
      cyc();
      c_res("sub15", 8'h1F, 8'h1F, 8'h00, 8'hFF);
      c_ovf("sub15", 1'b0, 1'b0, 1'b1, 1'b1);
      c_acc("sub15", 8'h00, 8'h00, 8'h00, 8'h00);

      drive(1'b1, 2'b11, 5'd0, 5'd0);
      cyc();
      c_res("clr1", 8'h00, 8'h00, 8'h00, 8'h00);
      c_ovf("clr1", 1'b0, 1'b0, 1'b0, 1'b0);
      c_hs("clr1", 1'b1, 1'b1);

      drive(1'b1, 2'b10, 5'd15, 5'd0);
      for (int k = 1; k <= 8; k++) begin
         logic [7:0] v;
         v = 8'(15 * k);
         cyc();
         c_acc($sformatf("acc15_%0d", k), v, v, v, v);
         c_res($sformatf("acc15_%0d", k), v, v, v, v);
      end
      cyc();
      c_acc("acc15_9", 8'h7F, 8'h87, 8'h87, 8'h87);
      c_res("acc15_9", 8'h7F, 8'h87, 8'h87, 8'h87);
      c_ovf("acc15_9", 1'b1, 1'b1, 1'b0, 1'b0);

      drive(1'b1, 2'b11, 5'd0, 5'd0);
      cyc();
      c_acc("clr2", 8'h00, 8'h00, 8'h00, 8'h00);
      c_res("clr2", 8'h00, 8'h00, 8'h00, 8'h00);
      c_ovf("clr2", 1'b0, 1'b0, 1'b0, 1'b0);

      drive(1'b1, 2'b01, 5'd3, 5'd5);
      cyc();
      c_res("sub35", 8'hFE, 8'hFE, 8'h00, 8'hFE);
      c_ovf("sub35", 1'b0, 1'b0, 1'b1, 1'b1);

      drive(1'b1, 2'b11, 5'd0, 5'd0);
      cyc();
      drive(1'b1, 2'b10, 5'h10, 5'd0);
      for (int k = 1; k <= 8; k++) cyc();
      c_acc("accn_8", 8'h80, 8'h80, 8'h80, 8'h80);
      c_ovf("accn_8", 1'b0, 1'b0, 1'b0, 1'b0);
      cyc();
      c_acc("accn_9", 8'h80, 8'h70, 8'h90, 8'h90);
      c_ovf("accn_9", 1'b1, 1'b1, 1'b0, 1'b0);

      drive(1'b1, 2'b11, 5'd0, 5'd0);
      cyc();
      drive(1'b1, 2'b10, 5'd31, 5'd0);
      for (int k = 1; k <= 8; k++) cyc();
      c_acc("acc31_8", 8'hF8, 8'hF8, 8'hF8, 8'hF8);
      cyc();
      c_acc("acc31_9", 8'hF7, 8'hF7, 8'hFF, 8'h17);
      c_res("acc31_9", 8'hF7, 8'hF7, 8'hFF, 8'h17);
      c_ovf("acc31_9", 1'b0, 1'b0, 1'b1, 1'b1);

      drive(1'b1, 2'b00, 5'd2, 5'd3);
      cyc();
      c_res("add23", 8'h05, 8'h05, 8'h05, 8'h05);
      out_ready = 1'b0;
      drive(1'b1, 2'b00, 5'd1, 5'd1);
      #1;
      c_hs("bp0", 1'b1, 1'b0);
      for (int k = 1; k <= 3; k++) begin
         cyc();
         c_hs($sformatf("bp%0d", k), 1'b1, 1'b0);
         c_res($sformatf("bp%0d", k), 8'h05, 8'h05, 8'h05, 8'h05);
         c_acc($sformatf("bp%0d", k), 8'hF7, 8'hF7, 8'hFF, 8'h17);
      end
      out_ready = 1'b1;
      #1;
      c_hs("rel", 1'b1, 1'b1);
      cyc();
      c_hs("add11", 1'b1, 1'b1);
      c_res("add11", 8'h02, 8'h02, 8'h02, 8'h02);

      out_ready = 1'b0;
      drive(1'b0, 2'b00, 5'd0, 5'd0);
      rst_n = 1'b0;
      cyc();
      c_hs("rst2", 1'b0, 1'b1);
      c_acc("rst2", 8'h00, 8'h00, 8'h00, 8'h00);
      c_res("rst2", 8'h00, 8'h00, 8'h00, 8'h00);
      c_ovf("rst2", 1'b0, 1'b0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
